ysyx_23060136_ifu_idu_seg: RTL and testbench

YSYX_23060136_IFU_IDU_SEG -- requirements
Module: ysyx_23060136_IFU_IDU_SEG

---
 rtl/ysyx_23060136_ifu_idu_seg.sv | 156 +++++++++++++++
 tb/tb_ysyx_23060136_ifu_idu_seg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060136_ifu_idu_seg.sv
// ysyx_23060136_ifu_idu_seg
// Pipeline segment between instruction fetch and decode, built as a
// two-entry FIFO (head, tail). Decode always sees the head entry; when the
// FIFO is empty it sees a bubble carrying NOP_INST.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   IFU_o_valid      fetch offers an instruction
//   IFU_o_pc         PC of the offered instruction
//   IFU_o_inst       offered instruction word
//   IFU_o_pre_take   predictor said taken for the offered instruction
//   IFU_i_ready      segment can accept (depends on state only)
//   IDU_i_pc         head PC (0 when empty)
//   IDU_i_inst       head instruction (NOP_INST when empty)
//   IDU_i_commit     head is a real instruction
//   IDU_i_pre_take   head predicted-taken bit (0 when empty)
//   EXU_o_ready      downstream consumes the head this cycle
//   BRANCH_flush     redirect: drop everything buffered and the current offer
//   SEG_o_stall_cnt  saturating count of cycles a valid head waited downstream

`ifndef ysyx_23060136_BITS_W
`define ysyx_23060136_BITS_W 64
`endif
`ifndef ysyx_23060136_INST_W
`define ysyx_23060136_INST_W 32
`endif

module ysyx_23060136_ifu_idu_seg #(
  parameter logic [`ysyx_23060136_INST_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             IFU_o_valid,
  input  logic [`ysyx_23060136_BITS_W-1:0] IFU_o_pc,
  input  logic [`ysyx_23060136_INST_W-1:0] IFU_o_inst,
  input  logic                             IFU_o_pre_take,
  output logic                             IFU_i_ready,
  output logic [`ysyx_23060136_BITS_W-1:0] IDU_i_pc,
  output logic [`ysyx_23060136_INST_W-1:0] IDU_i_inst,
  output logic                             IDU_i_commit,
  output logic                             IDU_i_pre_take,
  input  logic                             EXU_o_ready,
  input  logic                             BRANCH_flush,
  output logic [31:0]                      SEG_o_stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [`ysyx_23060136_BITS_W-1:0] head_pc, tail_pc;
  logic [`ysyx_23060136_INST_W-1:0] head_inst, tail_inst;
  logic                             head_pre, tail_pre;
  logic [31:0]                      stall_cnt;

  logic push, pop;

  // Ready and commit come from the state register only, so neither has a
  // combinational path from the fetch or execute handshakes.
  assign IFU_i_ready  = (state != FULL);
  assign IDU_i_commit = (state != EMPTY);

  // A flush cancels both handshakes in the cycle it is raised.
  assign push = IFU_o_valid && IFU_i_ready && !BRANCH_flush;
  assign pop  = IDU_i_commit && EXU_o_ready && !BRANCH_flush;

  // Outputs come straight from the head registers, masked to the bubble
  // values when the FIFO holds nothing.
  assign IDU_i_pc        = IDU_i_commit ? head_pc   : '0;
  assign IDU_i_inst      = IDU_i_commit ? head_inst : NOP_INST;
  assign IDU_i_pre_take  = IDU_i_commit ? head_pre  : 1'b0;
  assign SEG_o_stall_cnt = stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (BRANCH_flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) state_next = ONE;
        ONE: begin
          if (push && !pop)      state_next = FULL;
          else if (!push && pop) state_next = EMPTY;
        end
        FULL:  if (pop) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Entry registers only move on a push or when the tail slides into the
  // head; a push with a simultaneous pop in ONE overwrites the head directly
  // so the stream keeps one-per-cycle throughput.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_pc   <= '0;
      head_inst <= NOP_INST;
      head_pre  <= 1'b0;
      tail_pc   <= '0;
      tail_inst <= NOP_INST;
      tail_pre  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_pc   <= IFU_o_pc;
            head_inst <= IFU_o_inst;
            head_pre  <= IFU_o_pre_take;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_pc   <= IFU_o_pc;
            head_inst <= IFU_o_inst;
            head_pre  <= IFU_o_pre_take;
          end else if (push) begin
            tail_pc   <= IFU_o_pc;
            tail_inst <= IFU_o_inst;
            tail_pre  <= IFU_o_pre_take;
          end
        end
        FULL: begin
          if (pop) begin
            head_pc   <= tail_pc;
            head_inst <= tail_inst;
            head_pre  <= tail_pre;
          end
        end
        default: ;
      endcase
    end
  end

  // Stall counter saturates instead of wrapping and survives flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (IDU_i_commit && !EXU_o_ready && !BRANCH_flush &&
                 (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ysyx_23060136_ifu_idu_seg.sv
// Testbench for ysyx_23060136_ifu_idu_seg.
// Stimulus is driven just after each rising edge; a monitor on the falling
// edge compares the DUT against a queue-based reference of the buffered
// instructions, then advances that reference by one clock.

module tb_ysyx_23060136_ifu_idu_seg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        pre;
  } entry_t;

  logic        clk;
  logic        rst;
  logic        ifu_valid;
  logic [63:0] ifu_pc;
  logic [31:0] ifu_inst;
  logic        ifu_pre;
  logic        ifu_ready;
  logic [63:0] idu_pc;
  logic [31:0] idu_inst;
  logic        idu_commit;
  logic        idu_pre;
  logic        exu_ready;
  logic        flush;
  logic [31:0] stall_cnt;

  entry_t      model_q[$];
  logic [31:0] model_cnt;
  bit          armed;
  int          vectors;
  int          miscompares;

  ysyx_23060136_ifu_idu_seg #(.NOP_INST(NOP)) dut (
    .clk             (clk),
    .rst             (rst),
    .IFU_o_valid     (ifu_valid),
    .IFU_o_pc        (ifu_pc),
    .IFU_o_inst      (ifu_inst),
    .IFU_o_pre_take  (ifu_pre),
    .IFU_i_ready     (ifu_ready),
    .IDU_i_pc        (idu_pc),
    .IDU_i_inst      (idu_inst),
    .IDU_i_commit    (idu_commit),
    .IDU_i_pre_take  (idu_pre),
    .EXU_o_ready     (exu_ready),
    .BRANCH_flush    (flush),
    .SEG_o_stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then wait until just after the next rising edge.
  task automatic applyStimulus(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                               input logic pre, input logic exu, input logic fl, input logic r);
    ifu_valid = v;
    ifu_pc    = pc;
    ifu_inst  = inst;
    ifu_pre   = pre;
    exu_ready = exu;
    flush     = fl;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare current outputs against the reference, then advance it
  // using the inputs that the coming rising edge will sample.
  always @(negedge clk) begin
    entry_t e;
    int     sz;
    if (armed) begin
      sz = model_q.size();
      checkOutput("commit", {63'd0, idu_commit}, {63'd0, sz != 0});
      checkOutput("ready", {63'd0, ifu_ready}, {63'd0, sz < 2});
      if (sz != 0) begin
        checkOutput("pc", idu_pc, model_q[0].pc);
        checkOutput("inst", {32'd0, idu_inst}, {32'd0, model_q[0].inst});
        checkOutput("pre_take", {63'd0, idu_pre}, {63'd0, model_q[0].pre});
      end else begin
        checkOutput("bubble_pc", idu_pc, 64'd0);
        checkOutput("bubble_inst", {32'd0, idu_inst}, {32'd0, NOP});
        checkOutput("bubble_pre", {63'd0, idu_pre}, 64'd0);
      end
      checkOutput("stall_cnt", {32'd0, stall_cnt}, {32'd0, model_cnt});
    end
    if (rst) begin
      model_q.delete();
      model_cnt = 32'd0;
      armed = 1'b1;
    end else if (flush) begin
      model_q.delete();
    end else begin
      sz = model_q.size();
      if (sz != 0 && !exu_ready && model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
      if (sz != 0 && exu_ready) void'(model_q.pop_front());
      if (ifu_valid && sz < 2) begin
        e.pc = ifu_pc;
        e.inst = ifu_inst;
        e.pre = ifu_pre;
        model_q.push_back(e);
      end
    end
  end

  initial begin
    armed = 1'b0;
    vectors = 0;
    miscompares = 0;
    model_cnt = 32'd0;
    ifu_valid = 1'b0;
    ifu_pc = '0;
    ifu_inst = '0;
    ifu_pre = 1'b0;
    exu_ready = 1'b0;
    flush = 1'b0;
    rst = 1'b1;

    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    $display("[TB] single instruction then bubble");
    applyStimulus(1, 64'h8000_0000, 32'h0000_0297, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);

    $display("[TB] fill under stall, third offer refused");
    applyStimulus(1, 64'h100, 32'h1111_1111, 1, 0, 0, 0);
    applyStimulus(1, 64'h104, 32'h2222_2222, 0, 0, 0, 0);
    applyStimulus(1, 64'h108, 32'h3333_3333, 1, 0, 0, 0);
    applyStimulus(1, 64'h108, 32'h3333_3333, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);

    $display("[TB] streaming push plus pop");
    applyStimulus(1, 64'h200, 32'h0000_0200, 0, 1, 0, 0);
    applyStimulus(1, 64'h204, 32'h0000_0204, 1, 1, 0, 0);
    applyStimulus(1, 64'h208, 32'h0000_0208, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);

    $display("[TB] flush while full with a concurrent offer");
    applyStimulus(1, 64'h2f0, 32'hAAAA_0001, 0, 0, 0, 0);
    applyStimulus(1, 64'h2f4, 32'hAAAA_0002, 0, 0, 0, 0);
    applyStimulus(1, 64'h300, 32'hBBBB_0300, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);

    $display("[TB] stall counter saturation and mid-stream reset");
    applyStimulus(1, 64'h400, 32'hCCCC_0400, 0, 0, 0, 0);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    model_cnt = 32'hFFFF_FFFE;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 64'h404, 32'hCCCC_0404, 0, 0, 0, 0);
    applyStimulus(1, 64'h408, 32'hCCCC_0408, 1, 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    {32'd0, $urandom} & 64'hFFFF_FFFC,
                    $urandom,
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, 2) != 0,
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 63) == 0);
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
